// File: rtl/otter_prog_pkg.sv
// Shared types and helpers for the OTTER UART program loader.
package otter_prog_pkg;

    // Loader FSM states; CHK and HOLD are only reachable with PROG_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
        ST_CHK,
        ST_HOLD
    } prog_state_t;

    localparam logic [7:0] DEFAULT_START_BYTE = 8'hA5;

    // Clock cycles per UART bit, truncated
    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/otter_uart_programmer_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, start-bit recheck at half bit,
// centre sampling, one-cycle rx_valid / rx_ferr pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       SRX,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_ferr
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic [1:0]    sync_q;
    logic          prev_q;
    logic          rx_s;
    rx_state_t     st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    assign rx_s     = sync_q[1];
    assign rx_valid = valid_q;
    assign rx_data  = shift_q;
    assign rx_ferr  = ferr_q;

    // Frame timing: detect start edge, sample bits at centres, judge stop bit
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (st_q)
            RX_IDLE: begin
                if (prev_q && !rx_s) begin
                    st_d  = RX_START;
                    cnt_d = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF) begin
                    // a start bit that has gone high again was a glitch
                    cnt_d = '0;
                    bit_d = '0;
                    st_d  = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) st_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    st_d    = RX_IDLE;
                    valid_d = rx_s;
                    ferr_d  = !rx_s;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: st_d = RX_IDLE;
        endcase
    end

    // Synchronizer and receiver state; line flops reset to idle-high
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            st_q    <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], SRX};
            prev_q  <= rx_s;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

endmodule

// File: rtl/otter_uart_programmer.sv
// UART program loader for OTTER: START_BYTE, 16-bit word count (LE), then
// 4N data bytes written word-by-word while the MCU is held in reset.
// Optional macro PROG_CHECKSUM_EN adds a trailing XOR checksum byte.
module otter_uart_programmer
    import otter_prog_pkg::*;
#(
    parameter int         CLK_FREQ    = 100_000_000,
    parameter int         BAUD        = 115200,
    parameter int         ADDR_W      = 14,
    parameter int         TIMEOUT_CYC = 10_000_000,
    parameter logic [7:0] START_BYTE  = DEFAULT_START_BYTE
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              SRX,
    output logic              MCU_RST,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [31:0]       MEM_DATA,
    output logic              PROG_BUSY,
    output logic              PROG_ERR
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ferr;

    uart_rx #(.CLKS_PER_BIT(CPB)) u_rx (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .SRX      (SRX),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ferr  (rx_ferr)
    );

    prog_state_t       state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [16:0]       idx_q, idx_d;
    logic [31:0]       tmo_q, tmo_d;
    logic              mcu_rst_q, mcu_rst_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
`ifdef PROG_CHECKSUM_EN
    logic [7:0]        chk_q, chk_d;
`endif

    logic [15:0] len_full;
    logic [16:0] idx_nxt;
    logic [31:0] word_nxt;
    logic        in_session;
    logic        tmo_hit;

    assign len_full   = {rx_data, len_q[7:0]};
    assign idx_nxt    = idx_q + 17'd1;
    assign word_nxt   = {rx_data, word_q[31:8]};
    assign in_session = state_q inside {ST_LEN0, ST_LEN1, ST_DATA, ST_WRITE, ST_CHK};
    assign tmo_hit    = (tmo_q == 32'(TIMEOUT_CYC - 1)) && !rx_valid;

    assign MCU_RST   = mcu_rst_q;
    assign MEM_WE    = we_q;
    assign MEM_ADDR  = addr_q;
    assign MEM_DATA  = data_q;
    assign PROG_BUSY = busy_q;
    assign PROG_ERR  = err_q;

    // Session sequencing, word assembly and session-abort handling
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        word_d    = word_q;
        bcnt_d    = bcnt_q;
        idx_d     = idx_q;
        mcu_rst_d = mcu_rst_q;
        busy_d    = busy_q;
        err_d     = err_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
`ifdef PROG_CHECKSUM_EN
        chk_d     = chk_q;
`endif
        // idle-gap timer only runs while a session is waiting for bytes
        tmo_d = (rx_valid || state_q inside {ST_IDLE, ST_DONE, ST_HOLD}) ? '0 : tmo_q + 32'd1;

        if (in_session && (rx_ferr || tmo_hit)) begin
            // abort: release the MCU, keep whatever was already written
            err_d     = 1'b1;
            mcu_rst_d = 1'b0;
            busy_d    = 1'b0;
            state_d   = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_valid && rx_data == START_BYTE) begin
                        state_d   = ST_LEN0;
                        mcu_rst_d = 1'b1;
                        busy_d    = 1'b1;
                        err_d     = 1'b0;
`ifdef PROG_CHECKSUM_EN
                        chk_d     = '0;
`endif
                    end
                end
                ST_LEN0: begin
                    if (rx_valid) begin
                        len_d[7:0] = rx_data;
                        state_d    = ST_LEN1;
                    end
                end
                ST_LEN1: begin
                    if (rx_valid) begin
                        len_d  = len_full;
                        idx_d  = '0;
                        bcnt_d = '0;
                        if (len_full == 16'd0) begin
`ifdef PROG_CHECKSUM_EN
                            state_d = ST_CHK;
`else
                            state_d = ST_DONE;
`endif
                        end else if (32'(len_full) > (32'd1 << ADDR_W)) begin
                            err_d     = 1'b1;
                            mcu_rst_d = 1'b0;
                            busy_d    = 1'b0;
                            state_d   = ST_IDLE;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_valid) begin
                        // bytes shift in from the top so the first lands in [7:0]
                        word_d = word_nxt;
                        bcnt_d = bcnt_q + 2'd1;
`ifdef PROG_CHECKSUM_EN
                        chk_d  = chk_q ^ rx_data;
`endif
                        if (bcnt_q == 2'd3) begin
                            state_d = ST_WRITE;
                            we_d    = 1'b1;
                            addr_d  = idx_q[ADDR_W-1:0];
                            data_d  = word_nxt;
                        end
                    end
                end
                ST_WRITE: begin
                    idx_d = idx_nxt;
                    if (idx_nxt == {1'b0, len_q}) begin
`ifdef PROG_CHECKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_DONE: begin
                    mcu_rst_d = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end
`ifdef PROG_CHECKSUM_EN
                ST_CHK: begin
                    if (rx_valid) begin
                        if (rx_data == chk_q) begin
                            state_d = ST_DONE;
                        end else begin
                            // bad image: keep the MCU parked until a reload
                            err_d   = 1'b1;
                            busy_d  = 1'b0;
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (rx_valid && rx_data == START_BYTE) begin
                        state_d = ST_LEN0;
                        busy_d  = 1'b1;
                        err_d   = 1'b0;
                        chk_d   = '0;
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Loader state and registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            word_q    <= '0;
            bcnt_q    <= '0;
            idx_q     <= '0;
            tmo_q     <= '0;
            mcu_rst_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
`ifdef PROG_CHECKSUM_EN
            chk_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            word_q    <= word_d;
            bcnt_q    <= bcnt_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            mcu_rst_q <= mcu_rst_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
`ifdef PROG_CHECKSUM_EN
            chk_q     <= chk_d;
`endif
        end
    end

endmodule
